// File: rtl/qtree_lookup_shaper.sv
`default_nettype none
// ============================================================================
// Module      : qtree_lookup_shaper
// Description : Credit-gated request issue into the quad-tree lookup port and
//               a show-ahead result FIFO with valid/ready egress.
// Revision    : 1.0 - initial release
// ============================================================================
module qtree_lookup_shaper #(
    parameter int KEY_WIDTH    = 16,
    parameter int BYPASS_WIDTH = 1,
    parameter int ADDR_WIDTH   = 12,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [KEY_WIDTH-1:0]    req_data_i,
    input  logic [BYPASS_WIDTH-1:0] req_bypass_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    output logic [KEY_WIDTH-1:0]    lookup_data_o,
    output logic [BYPASS_WIDTH-1:0] lookup_bypass_o,
    output logic                    lookup_valid_o,
    input  logic                    lookup_valid_i,
    input  logic                    lookup_match_i,
    input  logic [BYPASS_WIDTH-1:0] lookup_bypass_i,
    input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic                    res_match_o,
    output logic [BYPASS_WIDTH-1:0] res_bypass_o,
    output logic [ADDR_WIDTH-1:0]   res_addr_o,
    output logic [CNT_WIDTH-1:0]    credit_o,
    output logic [CNT_WIDTH-1:0]    inflight_o,
    output logic                    err_o
);

    localparam int c_ptr_width   = $clog2(FIFO_DEPTH);
    localparam int c_entry_width = 1 + BYPASS_WIDTH + ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0]   c_depth   = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]   c_cnt_one = CNT_WIDTH'(1);
    localparam logic [c_ptr_width-1:0] c_ptr_one = c_ptr_width'(1);

    logic [CNT_WIDTH-1:0]     r_credit;
    logic [CNT_WIDTH-1:0]     r_inflight;
    logic [CNT_WIDTH-1:0]     r_count;
    logic [c_ptr_width-1:0]   r_wr_ptr;
    logic [c_ptr_width-1:0]   r_rd_ptr;
    logic                     r_lookup_valid;
    logic [KEY_WIDTH-1:0]     r_lookup_data;
    logic [BYPASS_WIDTH-1:0]  r_lookup_bypass;
    logic                     r_err;
    logic [c_entry_width-1:0] r_mem [FIFO_DEPTH];

    logic w_accept;
    logic w_pop;
    logic w_full;
    logic w_push_ok;
    logic w_issue;
    logic w_ret;

    assign req_ready_o = (r_credit != '0) && !rst_i;
    assign w_accept    = req_valid_i && req_ready_o;
    assign res_valid_o = (r_count != '0);
    assign w_pop       = res_valid_o && res_ready_i;
    assign w_full      = (r_count == c_depth);
    assign w_push_ok   = lookup_valid_i && !w_full;
    // A lookup counts as in flight once its strobe is actually on the tree port.
    assign w_issue     = r_lookup_valid;
    assign w_ret       = lookup_valid_i;

    assign lookup_valid_o  = r_lookup_valid;
    assign lookup_data_o   = r_lookup_data;
    assign lookup_bypass_o = r_lookup_bypass;
    assign credit_o        = r_credit;
    assign inflight_o      = r_inflight;
    assign err_o           = r_err;
    assign {res_match_o, res_bypass_o, res_addr_o} = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credit        <= c_depth;
            r_inflight      <= '0;
            r_count         <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_lookup_valid  <= 1'b0;
            r_lookup_data   <= '0;
            r_lookup_bypass <= '0;
            r_err           <= 1'b0;
        end else begin
            r_lookup_valid <= w_accept;
            if (w_accept) begin
                r_lookup_data   <= req_data_i;
                r_lookup_bypass <= req_bypass_i;
            end

            if (w_accept && !w_pop) begin
                r_credit <= r_credit - c_cnt_one;
            end else if (w_pop && !w_accept && (r_credit != c_depth)) begin
                r_credit <= r_credit + c_cnt_one;
            end

            if (w_issue && !w_ret && (r_inflight != c_depth)) begin
                r_inflight <= r_inflight + c_cnt_one;
            end else if (w_ret && !w_issue && (r_inflight != '0)) begin
                r_inflight <= r_inflight - c_cnt_one;
            end

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - c_cnt_one;
            end

            // Result with nothing outstanding, or with nowhere to store it.
            if ((w_ret && (r_inflight == '0)) || (lookup_valid_i && w_full)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {lookup_match_i, lookup_bypass_i, lookup_addr_i};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qtree_lookup_shaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_qtree_lookup_shaper
// Description : Scoreboard bench with a fixed-latency tree model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qtree_lookup_shaper;

    localparam int KW = 16;
    localparam int BW = 1;
    localparam int AW = 12;
    localparam int DEPTH = 16;
    localparam int CW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [KW-1:0] req_data_i = '0;
    logic [BW-1:0] req_bypass_i = '0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [KW-1:0] lookup_data_o;
    logic [BW-1:0] lookup_bypass_o;
    logic          lookup_valid_o;
    logic          lookup_valid_i = 1'b0;
    logic          lookup_match_i = 1'b0;
    logic [BW-1:0] lookup_bypass_i = '0;
    logic [AW-1:0] lookup_addr_i = '0;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic          res_match_o;
    logic [BW-1:0] res_bypass_o;
    logic [AW-1:0] res_addr_o;
    logic [CW-1:0] credit_o;
    logic [CW-1:0] inflight_o;
    logic          err_o;

    qtree_lookup_shaper #(
        .KEY_WIDTH(KW), .BYPASS_WIDTH(BW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_data_i(req_data_i), .req_bypass_i(req_bypass_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .lookup_data_o(lookup_data_o), .lookup_bypass_o(lookup_bypass_o),
        .lookup_valid_o(lookup_valid_o), .lookup_valid_i(lookup_valid_i),
        .lookup_match_i(lookup_match_i), .lookup_bypass_i(lookup_bypass_i),
        .lookup_addr_i(lookup_addr_i), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .res_match_o(res_match_o),
        .res_bypass_o(res_bypass_o), .res_addr_o(res_addr_o),
        .credit_o(credit_o), .inflight_o(inflight_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          m;
        logic [BW-1:0] b;
        logic [AW-1:0] a;
    } res_t;

    typedef struct packed {
        int            due;
        logic [KW-1:0] k;
        logic [BW-1:0] b;
    } tq_t;

    res_t    sbq[$];
    tq_t     tq[$];
    int      n_vec = 0;
    int      n_err = 0;
    int      cyc = 0;
    int      lat = 6;
    int      mcount = 0;
    int      acc_total = 0;
    int      pop_total = 0;
    int      tree_ret = 0;
    int      req_mode = 0;
    int      rdy_mode = 0;
    bit      inj = 1'b0;
    bit      acc_flag = 1'b0;
    logic [KW-1:0] key = 16'h1234;

    // Tree response: parity of the key as match, key low bits XOR a fixed mask as address.
    function automatic res_t tree_fn(input logic [KW-1:0] k, input logic [BW-1:0] b);
        res_t r;
        r.m = ^k;
        r.b = b;
        r.a = k[AW-1:0] ^ 12'h26E;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        if (acc_flag) begin
            acc_flag = 1'b0;
            key = key + 16'h0111;
        end
        req_data_i   = key;
        req_bypass_i = key[2];
        req_valid_i  = (req_mode == 2) ? 1'($urandom_range(0, 1)) : (req_mode == 1);
        res_ready_i  = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        sbq.delete();
        acc_flag = 1'b0;
    endtask

    task automatic wait_drain(input int limit, input string name);
        int g = 0;
        while ((sbq.size() != 0 || tq.size() != 0 || inflight_o != '0 || lookup_valid_o
                || res_valid_o) && g < limit) begin
            step();
            g++;
        end
        chk(name, 32'(g < limit), 32'd1);
    endtask

    task automatic wait_tree_idle(input int limit, input string name);
        int g = 0;
        while ((tq.size() != 0 || inflight_o != '0 || lookup_valid_o) && g < limit) begin
            step();
            g++;
        end
        chk(name, 32'(g < limit), 32'd1);
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Occupancy model of the result FIFO.
    always @(posedge clk_i) begin
        if (rst_i) mcount <= 0;
        else mcount <= mcount + ((lookup_valid_i && mcount < DEPTH) ? 1 : 0)
                              - ((res_valid_o && res_ready_i) ? 1 : 0);
    end

    // Tree model: fixed latency, order preserving, no reset.
    always @(negedge clk_i) begin
        res_t r;
        lookup_valid_i = 1'b0;
        if (lookup_valid_o) tq.push_back('{cyc + lat, lookup_data_o, lookup_bypass_o});
        if (inj) begin
            lookup_valid_i  = 1'b1;
            lookup_match_i  = 1'b1;
            lookup_bypass_i = '0;
            lookup_addr_i   = '0;
            inj = 1'b0;
        end else if (tq.size() != 0 && tq[0].due <= cyc) begin
            r = tree_fn(tq[0].k, tq[0].b);
            lookup_valid_i  = 1'b1;
            lookup_match_i  = r.m;
            lookup_bypass_i = r.b;
            lookup_addr_i   = r.a;
            tq.delete(0);
            tree_ret++;
        end
    end

    // Scoreboard: push on accept, pop-and-compare on egress handshake.
    always @(negedge clk_i) begin
        res_t e;
        if (!rst_i) begin
            if (req_valid_i && req_ready_o) begin
                sbq.push_back(tree_fn(req_data_i, req_bypass_i));
                acc_total++;
                acc_flag = 1'b1;
            end
            if (res_valid_o && res_ready_i) begin
                pop_total++;
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: got result %0h expected none",
                             {res_match_o, res_bypass_o, res_addr_o});
                end else begin
                    e = sbq.pop_front();
                    chk("res_fields", 32'({res_match_o, res_bypass_o, res_addr_o}), 32'(e));
                end
            end
            if (!err_o) begin
                chk("invariant", 32'(credit_o) + 32'(inflight_o) + 32'(mcount) + 32'(lookup_valid_o),
                    32'(DEPTH));
                chk("res_valid_vs_count", 32'(res_valid_o), 32'(mcount != 0));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int p0;
        int g;
        int t0;

        // Reset state
        rst_i = 1'b1;
        step();
        step();
        chk("rst_credit", 32'(credit_o), 32'd16);
        chk("rst_inflight", 32'(inflight_o), 32'd0);
        chk("rst_res_valid", 32'(res_valid_o), 32'd0);
        chk("rst_lookup_valid", 32'(lookup_valid_o), 32'd0);
        chk("rst_lookup_data", 32'(lookup_data_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready_o), 32'd1);

        // Single request, key 0x1234 -> match=1, addr=0x05A, bypass=1
        lat = 6;
        req_mode = 1;
        step();
        req_mode = 0;
        step();
        chk("t1_strobe", 32'(lookup_valid_o), 32'd1);
        chk("t1_lookup_data", 32'(lookup_data_o), 32'h1234);
        chk("t1_lookup_bypass", 32'(lookup_bypass_o), 32'd1);
        chk("t1_credit", 32'(credit_o), 32'd15);
        step();
        chk("t1_strobe_off", 32'(lookup_valid_o), 32'd0);
        chk("t1_inflight", 32'(inflight_o), 32'd1);
        g = 0;
        while (!res_valid_o && g < 20) begin
            step();
            g++;
        end
        chk("t1_res_arrived", 32'(res_valid_o), 32'd1);
        chk("t1_res_match", 32'(res_match_o), 32'd1);
        chk("t1_res_addr", 32'(res_addr_o), 32'h05A);
        chk("t1_res_bypass", 32'(res_bypass_o), 32'd1);
        chk("t1_inflight_ret", 32'(inflight_o), 32'd0);
        rdy_mode = 1;
        step();
        rdy_mode = 0;
        step();
        chk("t1_credit_back", 32'(credit_o), 32'd16);
        chk("t1_empty", 32'(res_valid_o), 32'd0);

        // Fill with res_ready_i low
        a0 = acc_total;
        req_mode = 1;
        repeat (30) step();
        wait_tree_idle(60, "t2_idle_timeout");
        chk("t2_accepts", 32'(acc_total - a0), 32'd16);
        chk("t2_credit", 32'(credit_o), 32'd0);
        chk("t2_inflight", 32'(inflight_o), 32'd0);
        chk("t2_ready", 32'(req_ready_o), 32'd0);
        chk("t2_err", 32'(err_o), 32'd0);
        chk("t2_full_valid", 32'(res_valid_o), 32'd1);

        // One pop from full with requests held
        a0 = acc_total;
        rdy_mode = 1;
        step();
        rdy_mode = 0;
        step();
        chk("t3_credit_one", 32'(credit_o), 32'd1);
        chk("t3_ready_one", 32'(req_ready_o), 32'd1);
        step();
        chk("t3_credit_zero", 32'(credit_o), 32'd0);
        chk("t3_ready_zero", 32'(req_ready_o), 32'd0);
        chk("t3_one_accept", 32'(acc_total - a0), 32'd1);
        req_mode = 0;
        step();
        wait_tree_idle(40, "t3_idle_timeout");
        rdy_mode = 1;
        step();
        rdy_mode = 0;
        step();
        chk("t3_credit_pre", 32'(credit_o), 32'd1);
        req_mode = 1;
        rdy_mode = 1;
        step();
        req_mode = 0;
        rdy_mode = 0;
        step();
        chk("t3_simul_credit", 32'(credit_o), 32'd1);
        rdy_mode = 1;
        wait_drain(200, "t3_drain_timeout");
        chk("t3_credit_full", 32'(credit_o), 32'd16);

        // 40 random-handshake requests, tree latency 5
        lat = 5;
        a0 = acc_total;
        p0 = pop_total;
        req_mode = 2;
        rdy_mode = 2;
        g = 0;
        while (acc_total - a0 < 40 && g < 2000) begin
            step();
            g++;
        end
        req_mode = 0;
        req_valid_i = 1'b0;
        rdy_mode = 1;
        wait_drain(500, "t4_drain_timeout");
        chk("t4_accepts", 32'(acc_total - a0), 32'd40);
        chk("t4_pops", 32'(pop_total - p0), 32'd40);
        chk("t4_err", 32'(err_o), 32'd0);
        rdy_mode = 0;

        // Result with nothing in flight
        do_reset();
        chk("t5_err_clear", 32'(err_o), 32'd0);
        inj = 1'b1;
        step();
        chk("t5_err_set", 32'(err_o), 32'd1);
        chk("t5_inflight", 32'(inflight_o), 32'd0);
        step();
        step();
        chk("t5_err_sticky", 32'(err_o), 32'd1);
        chk("t5_inflight_hold", 32'(inflight_o), 32'd0);

        // Reset with 3 results queued and 2 in flight
        do_reset();
        chk("t6_err_clear", 32'(err_o), 32'd0);
        lat = 8;
        a0 = acc_total;
        t0 = tree_ret;
        req_mode = 1;
        g = 0;
        while (acc_total - a0 < 5 && g < 20) begin
            step();
            g++;
        end
        req_mode = 0;
        req_valid_i = 1'b0;
        g = 0;
        while (tree_ret - t0 < 3 && g < 40) begin
            step();
            g++;
        end
        chk("t6_inflight_two", 32'(inflight_o), 32'd2);
        chk("t6_err_pre", 32'(err_o), 32'd0);
        rst_i = 1'b1;
        #1;
        chk("t6_ready_in_rst", 32'(req_ready_o), 32'd0);
        step();
        rst_i = 1'b0;
        sbq.delete();
        chk("t6_res_valid", 32'(res_valid_o), 32'd0);
        chk("t6_credit", 32'(credit_o), 32'd16);
        chk("t6_inflight", 32'(inflight_o), 32'd0);
        g = 0;
        while (!err_o && g < 20) begin
            step();
            g++;
        end
        chk("t6_late_err", 32'(err_o), 32'd1);
        step();
        step();
        chk("t6_err_sticky", 32'(err_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
